cache_controller: RTL and testbench
===================================

# cache_controller

Sits between the MEM stage and the two-way data cache / SRAM controller pair, turning single-word MEM_R_EN/MEM_W_EN requests into cache lookups, SRAM line fetches and write-through stores. A read hit completes in the request cycle. A read miss fetches a 64-bit line from SRAM, fills the cache and returns the addressed word. Writes invalidate any matching cache line and are written through to SRAM; there is no write-allocate. `ready` low freezes the pipeline.

## Interface
Parameters:
- DATA_BASE, 1024: byte base address of data memory, subtracted before cache indexing.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- address  in  32  byte address from MEM stage, held stable while ready=0
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load data, valid when ready=1 with MEM_R_EN
- ready  out  1  request complete / no request pending
- cache_address  out  17  word address = (address − DATA_BASE)[18:2]
- cache_write_data  out  64  fill line, equals sram_rdata
- cache_read_en, cache_write_en, cache_invoke_en  out  1 each  cache controls
- cache_read_data  in  32  cache word
- cache_hit  in  1  cache hit
- sram_address  out  32  equals address
- sram_wdata  out  32  equals wdata
- sram_r_en, sram_w_en  out  1 each  SRAM controller requests, level-held until sram_ready
- sram_rdata  in  64  line {word1, word0}, valid with sram_ready
- sram_ready  in  1  one-cycle SRAM completion pulse

## Operation
- FSM states: IDLE, MISS, WRITE. Reset state is IDLE.
- IDLE, no request:
  - ready=1.
  - All cache/SRAM enables are 0.
- IDLE, MEM_W_EN=1 (priority over MEM_R_EN when both are set):
  - cache_invoke_en=1, sram_w_en=1, ready=0.
  - Go to WRITE.
- IDLE, MEM_R_EN=1, cache_hit=1:
  - cache_read_en=1, rdata=cache_read_data, ready=1 in the same cycle.
  - Stay in IDLE.
- IDLE, MEM_R_EN=1, cache_hit=0:
  - cache_read_en=1, sram_r_en=1, ready=0.
  - Go to MISS.
- MISS:
  - sram_r_en=1, ready=0 while sram_ready=0.
  - On the sram_ready cycle: cache_write_en=1; rdata = address[2] ? sram_rdata[63:32] : sram_rdata[31:0]; ready=1; sram_r_en stays 1 for that cycle; next state IDLE.
- WRITE:
  - sram_w_en=1, cache_invoke_en=1 held.
  - On sram_ready: ready=1, next state IDLE.
- rdata is 0 whenever it is not qualified (no read completing).
- Address arithmetic is a 32-bit subtract, truncated to bits [18:2]. Addresses below DATA_BASE wrap and are not checked.

## Timing
- Read hit: 0 extra cycles (combinational ready).
- Read miss: the request cycle, plus N cycles until sram_ready, plus the completion cycle. The cache is filled at the edge ending the sram_ready cycle.
- Write: same shape as a miss; invalidation takes effect in the first request cycle.
- The requester holds address, wdata and enables stable until it samples ready=1. Changes while ready=0 are a protocol violation; behaviour is undefined.
- Back-to-back requests: a new request may be presented the cycle after ready=1. It is evaluated from IDLE.
- sram_ready in IDLE is ignored.
- Reset:
  - With rst=1, outputs ready, rdata and all enables are 0.
  - At the next edge the state goes to IDLE, including mid-MISS or mid-WRITE. The aborted fill is not written to the cache.

## Configuration
- CACHE_CTRL_STATS_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], both cleared on rst.
  - hit_count increments on each IDLE read hit cycle; miss_count increments on each IDLE→MISS transition.
  - Both saturate at 16'hFFFF.
- Undefined: no such ports, no counters; behaviour otherwise identical.

## Test plan
- Reset, then MEM_R_EN=1, address=1024 (cache_address=0), cache_hit=0, sram_ready after 3 cycles with sram_rdata=64'h0000_0022_0000_0011 -> ready=0 for 3 cycles, then ready=1, rdata=32'h11, cache_write_en=1 in that cycle only.
- Same line, address=1028, cache_hit=1, cache_read_data=32'h22 -> ready=1 and rdata=32'h22 in the request cycle; sram_r_en stays 0.
- MEM_W_EN=1, address=1028, wdata=32'h55, sram_ready after 5 cycles -> cache_invoke_en=1 and sram_w_en=1 for 6 cycles, ready=1 on the 6th, sram_wdata=32'h55.
- MEM_R_EN=MEM_W_EN=1 -> WRITE path taken; sram_r_en never asserts.
- rst pulsed on the 2nd MISS cycle -> enables and ready are 0 during rst; state IDLE afterwards; a later sram_ready produces no cache_write_en.
- With CACHE_CTRL_STATS_EN: 2 hits + 1 miss -> hit_count=2, miss_count=1; preloaded to 16'hFFFF, a further hit leaves hit_count=16'hFFFF.

Source files
------------

// File: rtl/cache_controller.sv
// MEM-stage front end for a two-way data cache: read hits, SRAM line fills on miss, write-through stores.
// Defining CACHE_CTRL_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_controller #(
  parameter logic [31:0] DATA_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [16:0] cache_address,
  output logic [63:0] cache_write_data,
  output logic        cache_read_en,
  output logic        cache_write_en,
  output logic        cache_invoke_en,
  input  logic [31:0] cache_read_data,
  input  logic        cache_hit,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] w_offset;
  logic [31:0] w_fillWord;
  logic        w_unused;

  assign w_offset         = address - DATA_BASE;
  assign cache_address    = w_offset[18:2];
  assign w_unused         = &{1'b0, w_offset[31:19], w_offset[1:0]};
  assign cache_write_data = sram_rdata;
  assign sram_address     = address;
  assign sram_wdata       = wdata;
  assign w_fillWord       = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (MEM_W_EN)                    w_nextState = WRITE;
        else if (MEM_R_EN && !cache_hit) w_nextState = MISS;
      end
      MISS:    if (sram_ready) w_nextState = IDLE;
      WRITE:   if (sram_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Reset forces every handshake output low regardless of state.
  always_comb begin
    ready           = 1'b0;
    rdata           = 32'd0;
    cache_read_en   = 1'b0;
    cache_write_en  = 1'b0;
    cache_invoke_en = 1'b0;
    sram_r_en       = 1'b0;
    sram_w_en       = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (MEM_W_EN) begin
            cache_invoke_en = 1'b1;
            sram_w_en       = 1'b1;
          end else if (MEM_R_EN) begin
            cache_read_en = 1'b1;
            if (cache_hit) begin
              ready = 1'b1;
              rdata = cache_read_data;
            end else begin
              sram_r_en = 1'b1;
            end
          end else begin
            ready = 1'b1;
          end
        end
        MISS: begin
          sram_r_en = 1'b1;
          if (sram_ready) begin
            cache_write_en = 1'b1;
            ready          = 1'b1;
            rdata          = w_fillWord;
          end
        end
        WRITE: begin
          sram_w_en       = 1'b1;
          cache_invoke_en = 1'b1;
          ready           = sram_ready;
        end
        default: ready = 1'b0;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic w_hitEvent;
  logic w_missEvent;

  assign w_hitEvent  = (r_state == IDLE) && !MEM_W_EN && MEM_R_EN && cache_hit;
  assign w_missEvent = (r_state == IDLE) && !MEM_W_EN && MEM_R_EN && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (w_hitEvent && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (w_missEvent && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a transaction-level cache/SRAM model drives and predicts each request.
// Build with CACHE_CTRL_STATS_EN defined to also exercise the hit/miss counters.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [16:0] cache_address;
  logic [63:0] cache_write_data;
  logic        cache_read_en, cache_write_en, cache_invoke_en;
  logic [31:0] cache_read_data;
  logic        cache_hit;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [63:0] sramMem [int];
  logic [63:0] cacheLine [int];

  cache_controller #(.DATA_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_write_data(cache_write_data),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_invoke_en(cache_invoke_en), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int lineKey(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'd1024;
    return int'(off[18:3]);
  endfunction

  function automatic logic [63:0] memLine(input int key);
    if (!sramMem.exists(key)) sramMem[key] = {$urandom, $urandom};
    return sramMem[key];
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete request: predicted cycle-by-cycle from the cache/SRAM model, then the model is updated.
  task automatic runTxn(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input int n, input string tag);
    int          key;
    logic        hit;
    logic [63:0] line;
    logic [31:0] word, off;
    logic [16:0] expCa;
    logic [4:0]  expEn, gotEn;
    logic [31:0] expRd;
    logic        expReady;
    key  = lineKey(addr);
    off  = addr - 32'd1024;
    expCa = off[18:2];
    hit  = !we && re && cacheLine.exists(key);
    address  = addr;
    wdata    = wd;
    MEM_W_EN = we;
    MEM_R_EN = re;
    if (hit) begin
      line = cacheLine[key];
      word = addr[2] ? line[63:32] : line[31:0];
      cache_hit       = 1'b1;
      cache_read_data = word;
      sram_ready      = 1'b0;
      sram_rdata      = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || rdata !== word) begin
        failures++;
        $display("[TB] FAIL %s hit: ready=%b rdata=%h, required ready=1 rdata=%h", tag, ready, rdata, word);
      end
      gotEn = {cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en};
      checks++;
      if (gotEn !== 5'b10000) begin
        failures++;
        $display("[TB] FAIL %s hit_enables: got %b, required 10000", tag, gotEn);
      end
      checks++;
      if (cache_address !== expCa || sram_address !== addr) begin
        failures++;
        $display("[TB] FAIL %s addr: cache_address=%h sram_address=%h, required %h %h", tag, cache_address, sram_address, expCa, addr);
      end
      nextCycle();
      return;
    end
    line = memLine(key);
    word = addr[2] ? line[63:32] : line[31:0];
    cache_hit = 1'b0;
    for (int cyc = 0; cyc <= n; cyc++) begin
      cache_read_data = $urandom;
      sram_ready      = (cyc == n);
      sram_rdata      = (cyc == n) ? line : {$urandom, $urandom};
      expReady = (cyc == n);
      if (we) begin
        expEn = 5'b00101;
        expRd = 32'd0;
      end else begin
        expEn = {cyc == 0, cyc == n, 1'b0, 1'b1, 1'b0};
        expRd = (cyc == n) ? word : 32'd0;
      end
      @(negedge clk);
      gotEn = {cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en};
      checks++;
      if (ready !== expReady || rdata !== expRd) begin
        failures++;
        $display("[TB] FAIL %s cyc%0d: ready=%b rdata=%h, required ready=%b rdata=%h", tag, cyc, ready, rdata, expReady, expRd);
      end
      checks++;
      if (gotEn !== expEn) begin
        failures++;
        $display("[TB] FAIL %s cyc%0d enables: got %b, required %b", tag, cyc, gotEn, expEn);
      end
      if (cyc == n) begin
        checks++;
        if (cache_address !== expCa || sram_wdata !== wd || cache_write_data !== line) begin
          failures++;
          $display("[TB] FAIL %s data: cache_address=%h sram_wdata=%h line=%h, required %h %h %h",
                   tag, cache_address, sram_wdata, cache_write_data, expCa, wd, line);
        end
      end
      nextCycle();
    end
    sram_ready = 1'b0;
    if (we) begin
      if (addr[2]) sramMem[key][63:32] = wd;
      else         sramMem[key][31:0]  = wd;
      if (cacheLine.exists(key)) cacheLine.delete(key);
    end else begin
      cacheLine[key] = line;
    end
  endtask

  task automatic idleCycle(input string tag);
    logic [4:0] gotEn;
    MEM_R_EN        = 1'b0;
    MEM_W_EN        = 1'b0;
    cache_hit       = $urandom_range(0, 1);
    cache_read_data = $urandom;
    sram_ready      = $urandom_range(0, 1);
    @(negedge clk);
    gotEn = {cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en};
    checks++;
    if (ready !== 1'b1 || rdata !== 32'd0 || gotEn !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL %s idle: ready=%b rdata=%h en=%b, required 1 0 00000", tag, ready, rdata, gotEn);
    end
    nextCycle();
    sram_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] gotEn;
    rst = 1'b1;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; cache_hit = 1'b1;
    address = 32'd1024; wdata = 32'd0; cache_read_data = 32'hDEAD_BEEF;
    sram_ready = 1'b0; sram_rdata = 64'd0;
    nextCycle();
    @(negedge clk);
    gotEn = {cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en};
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0 || gotEn !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: ready=%b rdata=%h en=%b, required 0 0 00000", ready, rdata, gotEn);
    end
    nextCycle();
    rst = 1'b0;
    idleCycle("after_reset");
  endtask

  task automatic test_plan();
    sramMem[0] = 64'h0000_0022_0000_0011;
    runTxn(1'b0, 1'b1, 32'd1024, 32'd0, 3, "plan_miss");
    idleCycle("plan_gap1");
    runTxn(1'b0, 1'b1, 32'd1028, 32'd0, 0, "plan_hit");
    runTxn(1'b1, 1'b0, 32'd1028, 32'h55, 5, "plan_write");
    runTxn(1'b1, 1'b1, 32'd1024, 32'h77, 2, "plan_both");
    idleCycle("plan_gap2");
  endtask

  task automatic test_reset_mid_miss();
    logic [4:0] gotEn;
    if (cacheLine.exists(lineKey(32'd1200))) cacheLine.delete(lineKey(32'd1200));
    address = 32'd1200; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; cache_hit = 1'b0;
    sram_ready = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    gotEn = {cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en};
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0 || gotEn !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_mid_miss: ready=%b rdata=%h en=%b, required 0 0 00000", ready, rdata, gotEn);
    end
    nextCycle();
    rst = 1'b0;
    MEM_R_EN = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if (cache_write_en !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL late_sram_ready: cache_write_en=%b ready=%b, required 0 1", cache_write_en, ready);
    end
    nextCycle();
    sram_ready = 1'b0;
  endtask

  task automatic test_random();
    int          kind;
    logic [31:0] addr;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      addr = 32'd1024 + 32'($urandom_range(0, 31)) * 4;
      runTxn(kind >= 6, kind < 6 || kind == 9, addr, $urandom, $urandom_range(1, 6), "rand");
      if ($urandom_range(0, 3) == 0) idleCycle("rand_gap");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++)
      runTxn(1'b0, 1'b1, 32'd1024 + 32'(t % 4) * 8, 32'd0, 1, "b2b");
    runTxn(1'b1, 1'b0, 32'd1032, 32'h1234_5678, 1, "b2b_write");
    runTxn(1'b0, 1'b1, 32'd1032, 32'd0, 2, "b2b_refetch");
    idleCycle("b2b_end");
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    cacheLine.delete();
    runTxn(1'b0, 1'b1, 32'd1040, 32'd0, 2, "stats_miss");
    runTxn(1'b0, 1'b1, 32'd1040, 32'd0, 0, "stats_hit1");
    runTxn(1'b0, 1'b1, 32'd1044, 32'd0, 0, "stats_hit2");
    idleCycle("stats_gap");
    checks++;
    if (hit_count !== 16'd2 || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL stats_counts: hit=%0d miss=%0d, required 2 1", hit_count, miss_count);
    end
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; cache_hit = 1'b1; address = 32'd1040;
    for (int i = 0; i < 65540; i++) nextCycle();
    MEM_R_EN = 1'b0;
    @(negedge clk);
    checks++;
    if (hit_count !== 16'hFFFF || miss_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL stats_saturate: hit=%h miss=%0d, required FFFF 1", hit_count, miss_count);
    end
    nextCycle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; cache_hit = 1'b0;
    address = 32'd1024; wdata = 32'd0; cache_read_data = 32'd0;
    sram_ready = 1'b0; sram_rdata = 64'd0;
    test_reset();
    test_plan();
    test_reset_mid_miss();
    test_random();
    test_back_to_back();
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
